// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags, and a read-valid strobe. Any DEPTH >= 2 is supported.
//
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// mode: rd_data shows the head word continuously and rd_en pops it.
// Without the macro, an accepted read registers the head word into rd_data
// one clock later and pulses rd_valid for that cycle.
//
// Handshake: a write is taken at a rising edge when wr_en=1 and full=0;
// a read is taken when rd_en=1 and empty=0. Requests against full/empty
// are dropped and recorded in the sticky overflow/underflow flags.
// rd_valid=1 marks rd_data as a freshly popped word (standard mode) or as
// a valid head word (FWFT mode).
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  do_wr;
  logic                  do_rd;

  // Accept requests only when they can complete; flags decode from count.
  assign do_wr        = wr_en && !full;
  assign do_rd        = rd_en && !empty;
  assign full         = (count == CNT_WIDTH'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_WIDTH'(AF_LEVEL));
  assign almost_empty = (count <= CNT_WIDTH'(AE_LEVEL));

  // Storage array: written on accepted writes, never reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap by explicit compare so non-power-of-2 depths work.
  always_ff @(posedge clk) begin
    if (rst_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
    end
  end

  // Single occupancy counter: up on write-only, down on read-only.
  always_ff @(posedge clk) begin
    if (rst_) begin
      count <= '0;
    end else begin
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_WIDTH'(1);
        2'b01:   count <= count - CNT_WIDTH'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst_) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always on the output; rd_en only acknowledges it.
  assign rd_data  = mem[rd_ptr];
  assign rd_valid = !empty;
`else
  // Registered read port: one-clock latency, data held between pops.
  always_ff @(posedge clk) begin
    if (rst_) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_rd;
      if (do_rd) rd_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: randomized and directed bench for sync_fifo_param
// (DEPTH=16, DATA_WIDTH=16, AF=14, AE=2) against a queue-based model.
// Build with SYNC_FIFO_FWFT_EN to exercise first-word-fall-through mode.
module tb_sync_fifo_param;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] count;
  logic          overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd_data  = '0;
  logic          exp_rd_valid = 1'b0;
  logic          exp_ovf      = 1'b0;
  logic          exp_udf      = 1'b0;

  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  // Clock
  always #5 clk = ~clk;

  // Driver: apply one cycle of requests, update the model at the edge,
  // then leave outputs settled 1 time unit after the edge for checking.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic rs = 1'b0);
    int  sz;
    bit  wok, rok;
    wr_en = w; wr_data = d; rd_en = r; rst_ = rs;
    @(posedge clk);
    sz = exp_q.size();
    if (rs) begin
      exp_q.delete();
      exp_ovf = 1'b0; exp_udf = 1'b0;
      exp_rd_data = '0; exp_rd_valid = 1'b0;
    end else begin
      wok = w && (sz < DEPTH);
      rok = r && (sz > 0);
      if (w && sz == DEPTH) exp_ovf = 1'b1;
      if (r && sz == 0)     exp_udf = 1'b1;
`ifdef SYNC_FIFO_FWFT_EN
      if (rok) void'(exp_q.pop_front());
`else
      exp_rd_valid = rok;
      if (rok) exp_rd_data = exp_q.pop_front();
`endif
      if (wok) exp_q.push_back(d);
    end
`ifdef SYNC_FIFO_FWFT_EN
    exp_rd_valid = (exp_q.size() > 0);
    if (exp_rd_valid) exp_rd_data = exp_q[0];
`endif
    #1;
    wr_en = 1'b0; rd_en = 1'b0; rst_ = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, 16'h1234, 1'b1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b0);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_tests++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got=%b exp=1", almost_empty); end
    n_tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b/%b exp=0/0", full, almost_full); end
    n_tests++; if (count !== '0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (rd_data !== 16'h0000) begin n_fail++; $display("FAIL reset_rd_data got=%h exp=0000", rd_data); end
`endif
    n_tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin n_fail++; $display("FAIL reset_flags got=%b/%b exp=0/0", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, DW'(i), 1'b0);
      n_tests++; if (count !== CW'(i)) begin n_fail++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, count, i); end
      n_tests++; if (almost_full !== (i >= AF)) begin n_fail++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, almost_full, (i >= AF)); end
      n_tests++; if (full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == DEPTH)); end
    end
    step(1'b1, 16'hBEEF, 1'b0);
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fill_overflow got=%b exp=1", overflow); end
    n_tests++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL fill_count_ovf got=%0d exp=%0d", count, DEPTH); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin n_fail++; $display("FAIL drain_head[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, DW'(i)); end
      step(1'b0, '0, 1'b1);
`else
      step(1'b0, '0, 1'b1);
      n_tests++; if (rd_valid !== 1'b1 || rd_data !== DW'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rd_valid, rd_data, DW'(i)); end
      step(1'b0, '0, 1'b0);
      n_tests++; if (rd_valid !== 1'b0 || rd_data !== DW'(i)) begin n_fail++; $display("FAIL drain_hold[%0d] got=%b/%h exp=0/%h", i, rd_valid, rd_data, DW'(i)); end
`endif
    end
    step(1'b0, '0, 1'b1);
    n_tests++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL drain_underflow got=%b exp=1", underflow); end
    n_tests++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty got=%b/%b exp=0/1", rd_valid, empty); end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (rd_data !== 16'h0010) begin n_fail++; $display("FAIL drain_rd_hold got=%h exp=0010", rd_data); end
`endif
  endtask

  task automatic test_back_to_back();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, DW'($urandom_range(0, 16'hFFFF)), 1'b1);
      n_tests++; if (count !== 8) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d exp=8", i, count); end
      n_tests++; if (rd_valid !== exp_rd_valid || (exp_rd_valid && rd_data !== exp_rd_data)) begin
        n_fail++; $display("FAIL b2b_data[%0d] got=%b/%h exp=%b/%h", i, rd_valid, rd_data, exp_rd_valid, exp_rd_data);
      end
    end
  endtask

  task automatic test_corners();
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(16'h100 + i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b1);
    n_tests++; if (count !== CW'(DEPTH - 1) || overflow !== 1'b1 || full !== 1'b0) begin
      n_fail++; $display("FAIL full_wr_rd got=%0d/%b/%b exp=%0d/1/0", count, overflow, full, DEPTH - 1);
    end
`ifndef SYNC_FIFO_FWFT_EN
    n_tests++; if (rd_data !== 16'h0100) begin n_fail++; $display("FAIL full_wr_rd_data got=%h exp=0100", rd_data); end
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'h5A5A, 1'b1);
    n_tests++; if (count !== 1 || underflow !== 1'b1 || overflow !== 1'b0 || rd_valid !== exp_rd_valid) begin
      n_fail++; $display("FAIL empty_wr_rd got=%0d/%b/%b/%b exp=1/1/0/%b", count, underflow, overflow, rd_valid, exp_rd_valid);
    end
    for (int i = 0; i < 4; i++) step(1'b1, DW'(i), 1'b0);
    n_tests++; if (count !== 5) begin n_fail++; $display("FAIL pre_reset_count got=%0d exp=5", count); end
    step(1'b1, 16'h7777, 1'b1, 1'b1);
    n_tests++; if (count !== 0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got=%0d/%b/%b/%b exp=0/1/0/0", count, empty, overflow, underflow);
    end
  endtask

  task automatic test_random();
    logic w, r, rs;
    int   sz;
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      w  = ($urandom_range(0, 99) < 55);
      r  = ($urandom_range(0, 99) < 50);
      rs = ($urandom_range(0, 199) == 0);
      step(w, DW'($urandom_range(0, 16'hFFFF)), r, rs);
      sz = exp_q.size();
      n_tests++; if (count !== CW'(sz)) begin n_fail++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, count, sz); end
      n_tests++; if ({full, empty, almost_full, almost_empty} !== {sz == DEPTH, sz == 0, sz >= AF, sz <= AE}) begin
        n_fail++; $display("FAIL rnd_status[%0d] got=%b%b%b%b exp=%b%b%b%b", i, full, empty, almost_full, almost_empty,
                           sz == DEPTH, sz == 0, sz >= AF, sz <= AE);
      end
      n_tests++; if (overflow !== exp_ovf || underflow !== exp_udf) begin
        n_fail++; $display("FAIL rnd_flags[%0d] got=%b/%b exp=%b/%b", i, overflow, underflow, exp_ovf, exp_udf);
      end
      n_tests++; if (rd_valid !== exp_rd_valid || (exp_rd_valid && rd_data !== exp_rd_data)) begin
        n_fail++; $display("FAIL rnd_rd[%0d] got=%b/%h exp=%b/%h", i, rd_valid, rd_data, exp_rd_valid, exp_rd_data);
      end
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft();
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 16'hA5A5, 1'b0);
    n_tests++; if (rd_valid !== 1'b1 || rd_data !== 16'hA5A5) begin n_fail++; $display("FAIL fwft_show got=%b/%h exp=1/a5a5", rd_valid, rd_data); end
    step(1'b0, '0, 1'b1);
    n_tests++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_pop got=%b/%b exp=1/0", empty, rd_valid); end
  endtask
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_corners();
    test_random();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
